display_mode_controller: RTL and testbench
==========================================

// Module: display_mode_controller
// PURPOSE
//   Sequences the 4-digit display source (selector 0=current, 1=alarm, 2=keypad) for the alarm clock.
//   Manages timed alarm preview, keypad entry sessions with digit counting and inactivity timeout.
//   Issues one-cycle commit pulses that load entered digits into time or alarm registers.
//   Sits between button/keypad front-end and the display multiplexor; selector drives the mux directly.
// PARAMETERS
//   PREVIEW_SECS  5  one_sec ticks alarm preview stays up after show_alarm pulse
//   TIMEOUT_SECS  10 one_sec ticks without key_pressed before entry session aborts
//   CNT_W         4  width of seconds counter; must hold max(PREVIEW_SECS,TIMEOUT_SECS)
// PORTS
//   clk            in   1      system clock, all state on rising edge
//   reset_n        in   1      asynchronous active-low reset
//   one_sec        in   1      single-cycle 1 Hz tick
//   show_alarm     in   1      single-cycle pulse: start alarm preview
//   set_time       in   1      single-cycle pulse: start entry session targeting current time
//   set_alarm      in   1      single-cycle pulse: start entry session targeting alarm time
//   key_pressed    in   1      single-cycle pulse: one keypad digit accepted by keypad buffer
//   cancel         in   1      single-cycle pulse: abort preview/entry, return to current time
//   selector       out  2      display source: 2'h0 current, 2'h1 alarm, 2'h2 keypad
//   digit_count    out  3      digits entered in current session, 0..4
//   entry_active   out  1      high while in ENTRY state
//   commit_time    out  1      single-cycle pulse: load keypad value into current time
//   commit_alarm   out  1      single-cycle pulse: load keypad value into alarm time
//   clear_keypad   out  1      single-cycle pulse: clear keypad buffer at session start
// BEHAVIOUR
//   Reset: state=CURRENT, selector=0, digit_count=0, sec_cnt=0, target=0, all pulses/entry_active=0.
//   States: CURRENT (sel 0), PREVIEW (sel 1), ENTRY (sel 2). All outputs registered; selector
//     changes the cycle after the causing input.
//   Input priority in same cycle: cancel > set_time > set_alarm > show_alarm > key_pressed > one_sec.
//   CURRENT: set_time/set_alarm -> ENTRY, target latched (0=time,1=alarm), digit_count=0,
//     sec_cnt=0, clear_keypad pulse. show_alarm -> PREVIEW, sec_cnt=0. key_pressed ignored.
//   PREVIEW: one_sec increments sec_cnt; when incremented value reaches PREVIEW_SECS -> CURRENT.
//     show_alarm restarts sec_cnt=0. set_time/set_alarm enter ENTRY as from CURRENT.
//   ENTRY: key_pressed with digit_count<4 -> digit_count+1, sec_cnt=0. key_pressed when
//     digit_count becomes 4 -> next cycle commit_time or commit_alarm (per target) pulses for
//     exactly one cycle, state -> CURRENT, digit_count -> 0 in that same cycle.
//   ENTRY timeout: one_sec increments sec_cnt; reaching TIMEOUT_SECS -> CURRENT, no commit,
//     digit_count=0. key_pressed and one_sec same cycle: key wins, sec_cnt=0.
//   ENTRY: new set_time/set_alarm restarts session (new target, digit_count=0, clear_keypad);
//     show_alarm ignored.
//   cancel in any state -> CURRENT, digit_count=0, sec_cnt=0, no commit.
//   At most one of commit_time/commit_alarm/clear_keypad high in any cycle.
//   sec_cnt saturates, never wraps; counts only in PREVIEW/ENTRY.
//   reset_n low mid-session: immediate return to reset values, no commit emitted.
// TESTING
//   Reset then idle 20 one_sec ticks -> selector=0, no pulses.
//   show_alarm; 4 ticks -> selector=1; 5th tick -> selector=0 next cycle.
//   set_alarm, 4 key_pressed -> clear_keypad once, digit_count 1..4, single commit_alarm, selector=0.
//   set_time, 2 keys, 10 ticks without key -> selector=0, digit_count=0, no commit pulse.
//   set_time, 3 keys, cancel+key_pressed same cycle -> CURRENT, no commit_time.
//   set_time, 2 keys, set_alarm -> clear_keypad, count 0; 4 keys -> commit_alarm not commit_time.

Source files
------------

// File: rtl/display_mode_controller.sv
// Display source sequencer for the alarm clock: current time, alarm preview
// and keypad entry sessions with digit counting, timeout and commit pulses.
module display_mode_controller #(
  parameter int PREVIEW_SECS = 5,
  parameter int TIMEOUT_SECS = 10,
  parameter int CNT_W        = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       one_sec,
  input  logic       show_alarm,
  input  logic       set_time,
  input  logic       set_alarm,
  input  logic       key_pressed,
  input  logic       cancel,
  output logic [1:0] selector,
  output logic [2:0] digit_count,
  output logic       entry_active,
  output logic       commit_time,
  output logic       commit_alarm,
  output logic       clear_keypad
);

  typedef enum logic [1:0] {
    CURRENT = 2'd0,
    PREVIEW = 2'd1,
    ENTRY   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PV_LIM  = CNT_W'(PREVIEW_SECS);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_SECS);
  localparam logic [CNT_W-1:0] SEC_MAX = '1;
  localparam logic [2:0]       DIGITS  = 3'd4;

  state_t           state, state_n;
  logic [2:0]       cnt_n;
  logic [CNT_W-1:0] sec_cnt, sec_n, sec_inc;
  logic             target, tgt_n;
  logic             ct_n, ca_n, clr_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= CURRENT;
      digit_count  <= '0;
      sec_cnt      <= '0;
      target       <= 1'b0;
      commit_time  <= 1'b0;
      commit_alarm <= 1'b0;
      clear_keypad <= 1'b0;
    end else begin
      state        <= state_n;
      digit_count  <= cnt_n;
      sec_cnt      <= sec_n;
      target       <= tgt_n;
      commit_time  <= ct_n;
      commit_alarm <= ca_n;
      clear_keypad <= clr_n;
    end
  end

  // Saturating increment so a stalled limit can never wrap to zero
  assign sec_inc = (sec_cnt == SEC_MAX) ? sec_cnt : sec_cnt + 1'b1;

  always_comb begin
    state_n = state;
    cnt_n   = digit_count;
    sec_n   = sec_cnt;
    tgt_n   = target;
    ct_n    = 1'b0;
    ca_n    = 1'b0;
    clr_n   = 1'b0;
    if (cancel) begin
      state_n = CURRENT;
      cnt_n   = '0;
      sec_n   = '0;
    end else if (set_time || set_alarm) begin
      state_n = ENTRY;
      tgt_n   = !set_time;
      cnt_n   = '0;
      sec_n   = '0;
      clr_n   = 1'b1;
    end else begin
      unique case (state)
        CURRENT: begin
          sec_n = '0;
          if (show_alarm) state_n = PREVIEW;
        end
        PREVIEW: begin
          if (show_alarm) begin
            sec_n = '0;
          end else if (one_sec) begin
            if (sec_inc >= PV_LIM) begin
              state_n = CURRENT;
              sec_n   = '0;
            end else begin
              sec_n = sec_inc;
            end
          end
        end
        ENTRY: begin
          // Full entry is shown for one cycle, then committed
          if (digit_count == DIGITS) begin
            ct_n    = !target;
            ca_n    = target;
            state_n = CURRENT;
            cnt_n   = '0;
            sec_n   = '0;
          end else if (key_pressed) begin
            cnt_n = digit_count + 3'd1;
            sec_n = '0;
          end else if (one_sec) begin
            if (sec_inc >= TO_LIM) begin
              state_n = CURRENT;
              cnt_n   = '0;
              sec_n   = '0;
            end else begin
              sec_n = sec_inc;
            end
          end
        end
        default: begin
          state_n = CURRENT;
          cnt_n   = '0;
          sec_n   = '0;
        end
      endcase
    end
  end

  assign selector     = state;
  assign entry_active = (state == ENTRY);

endmodule

// File: tb/tb_display_mode_controller.sv
// Bench for display_mode_controller: countdown-based reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_display_mode_controller;

  localparam int PV = 5;
  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       one_sec = 1'b0;
  logic       show_alarm = 1'b0;
  logic       set_time = 1'b0;
  logic       set_alarm = 1'b0;
  logic       key_pressed = 1'b0;
  logic       cancel = 1'b0;
  logic [1:0] selector;
  logic [2:0] digit_count;
  logic       entry_active;
  logic       commit_time;
  logic       commit_alarm;
  logic       clear_keypad;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  display_mode_controller #(
    .PREVIEW_SECS(PV),
    .TIMEOUT_SECS(TO),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .one_sec(one_sec),
    .show_alarm(show_alarm),
    .set_time(set_time),
    .set_alarm(set_alarm),
    .key_pressed(key_pressed),
    .cancel(cancel),
    .selector(selector),
    .digit_count(digit_count),
    .entry_active(entry_active),
    .commit_time(commit_time),
    .commit_alarm(commit_alarm),
    .clear_keypad(clear_keypad)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0/1/2, remaining ticks until auto-return
  int  m_sel, m_cnt, m_left, m_tgt;
  bit  m_pend, m_ct, m_ca, m_clr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_sel = 0; m_cnt = 0; m_left = 0; m_tgt = 0;
      m_pend = 0; m_ct = 0; m_ca = 0; m_clr = 0;
    end else begin
      m_ct = 0; m_ca = 0; m_clr = 0;
      if (cancel) begin
        m_sel = 0; m_cnt = 0; m_pend = 0;
      end else if (set_time || set_alarm) begin
        m_sel = 2; m_cnt = 0; m_left = TO; m_pend = 0;
        m_tgt = set_time ? 0 : 1;
        m_clr = 1;
      end else if (m_sel == 2 && m_pend) begin
        if (m_tgt == 0) m_ct = 1; else m_ca = 1;
        m_sel = 0; m_cnt = 0; m_pend = 0;
      end else if (m_sel == 0) begin
        if (show_alarm) begin
          m_sel = 1; m_left = PV;
        end
      end else if (m_sel == 1) begin
        if (show_alarm) m_left = PV;
        else if (one_sec) begin
          m_left--;
          if (m_left == 0) m_sel = 0;
        end
      end else begin
        if (key_pressed && m_cnt < 4) begin
          m_cnt++;
          m_left = TO;
          if (m_cnt == 4) m_pend = 1;
        end else if (one_sec) begin
          m_left--;
          if (m_left == 0) begin
            m_sel = 0; m_cnt = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("selector", selector, m_sel);
      chk("digit_count", digit_count, m_cnt);
      chk("entry_active", entry_active, m_sel == 2);
      chk("commit_time", commit_time, m_ct);
      chk("commit_alarm", commit_alarm, m_ca);
      chk("clear_keypad", clear_keypad, m_clr);
      checks++;
      if (int'(commit_time) + int'(commit_alarm) + int'(clear_keypad) > 1) begin
        errors++;
        $display("FAIL pulse_exclusive: got %0b%0b%0b expected at most one",
                 commit_time, commit_alarm, clear_keypad);
      end
    end
  end

  // Inputs asserted from a falling edge to just past the next rising edge
  task automatic drive(input bit t, input bit sa, input bit st,
                       input bit sal, input bit kp, input bit cn);
    @(negedge clk);
    one_sec = t; show_alarm = sa; set_time = st;
    set_alarm = sal; key_pressed = kp; cancel = cn;
    @(posedge clk);
    #1;
    one_sec = 0; show_alarm = 0; set_time = 0;
    set_alarm = 0; key_pressed = 0; cancel = 0;
  endtask

  task automatic idle();     drive(0, 0, 0, 0, 0, 0); endtask
  task automatic tick();     drive(1, 0, 0, 0, 0, 0); endtask
  task automatic key();      drive(0, 0, 0, 0, 1, 0); endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_selector", selector, 0);
    chk("rst_digit_count", digit_count, 0);
    chk("rst_pulses", {commit_time, commit_alarm, clear_keypad, entry_active}, 0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) tick();
    chk("idle_selector", selector, 0);

    drive(0, 1, 0, 0, 0, 0);
    chk("preview_start", selector, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("preview_4_ticks", selector, 1);
    tick();
    chk("preview_5th_tick", selector, 0);

    drive(0, 0, 0, 1, 0, 0);
    chk("alarm_clear", clear_keypad, 1);
    chk("alarm_entry", entry_active, 1);
    for (int i = 1; i <= 4; i++) begin
      key();
      chk("alarm_digits", digit_count, i);
    end
    chk("alarm_no_early_commit", commit_alarm, 0);
    idle();
    chk("alarm_commit", commit_alarm, 1);
    chk("alarm_commit_sel", selector, 0);
    chk("alarm_commit_cnt", digit_count, 0);
    idle();
    chk("alarm_commit_once", commit_alarm, 0);

    drive(0, 0, 1, 0, 0, 0);
    key(); key();
    for (int i = 0; i < 9; i++) tick();
    chk("timeout_9", selector, 2);
    tick();
    chk("timeout_sel", selector, 0);
    chk("timeout_cnt", digit_count, 0);
    idle(); idle();

    drive(0, 0, 1, 0, 0, 0);
    key(); key(); key();
    drive(0, 0, 0, 0, 1, 1);
    chk("cancel_sel", selector, 0);
    chk("cancel_cnt", digit_count, 0);
    idle();
    chk("cancel_no_commit", commit_time, 0);

    drive(0, 0, 1, 0, 0, 0);
    key(); key();
    drive(0, 0, 0, 1, 0, 0);
    chk("restart_clear", clear_keypad, 1);
    chk("restart_cnt", digit_count, 0);
    for (int i = 0; i < 4; i++) key();
    idle();
    chk("restart_commit_alarm", commit_alarm, 1);
    chk("restart_no_commit_time", commit_time, 0);
    idle();

    drive(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) key();
    idle();
    chk("both_set_commit_time", commit_time, 1);
    idle();

    drive(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick();
    drive(1, 0, 0, 0, 1, 0);
    chk("key_beats_tick", digit_count, 1);
    for (int i = 0; i < 9; i++) tick();
    chk("key_restarts_timer", selector, 2);
    tick();
    chk("timeout_after_key", selector, 0);

    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("preview_restart", selector, 1);
    tick();
    chk("preview_restart_end", selector, 0);

    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("preview_to_entry", selector, 2);
    drive(0, 1, 0, 0, 0, 0);
    chk("entry_ignores_show", selector, 2);
    drive(0, 0, 0, 0, 0, 1);

    drive(0, 0, 0, 1, 0, 0);
    key(); key(); key(); key();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_sel", selector, 0);
    chk("midreset_cnt", digit_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    idle();
    chk("midreset_no_commit", commit_alarm, 0);
    key();
    chk("current_ignores_key", digit_count, 0);
    repeat (3) idle();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
